// File: rtl/issue_queue_gen.sv
// Collapsing issue queue (reservation station) for a single execution unit.
// Entries 0..count-1 are live with index 0 the oldest. The oldest entry whose
// operands are both valid is presented on the issue port. When it is taken,
// every younger entry shifts down one slot. Operands that are still missing
// are captured from the CDB, and the entry being dispatched can also capture
// them in the same cycle.
module issue_queue_gen #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter bit IMM_EN = 1'b1,
    parameter bit PC_EN  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    // dispatch side
    input  logic                         disp_valid,
    input  logic [TAG_W-1:0]             disp_rs1_tag,
    input  logic [TAG_W-1:0]             disp_rs2_tag,
    input  logic [DATA_W-1:0]            disp_rs1_data,
    input  logic [DATA_W-1:0]            disp_rs2_data,
    input  logic                         disp_rs1_valid,
    input  logic                         disp_rs2_valid,
    input  logic [TAG_W-1:0]             disp_rd_tag,
    input  logic [6:0]                   disp_opcode,
    input  logic [6:0]                   disp_funct7,
    input  logic [2:0]                   disp_funct3,
    input  logic [DATA_W-1:0]            disp_imm,
    input  logic [DATA_W-1:0]            disp_pc,
    output logic                         queue_full,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    // result broadcast
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    // issue side
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [DATA_W-1:0]            issue_rs1_data,
    output logic [DATA_W-1:0]            issue_rs2_data,
    output logic [TAG_W-1:0]             issue_rd_tag,
    output logic [6:0]                   issue_opcode,
    output logic [6:0]                   issue_funct7,
    output logic [2:0]                   issue_funct3,
    output logic [DATA_W-1:0]            issue_imm,
    output logic [DATA_W-1:0]            issue_pc
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  rs1_tag;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic              rs1_v;
        logic              rs2_v;
        logic [TAG_W-1:0]  rd_tag;
        logic [6:0]        opcode;
        logic [6:0]        funct7;
        logic [2:0]        funct3;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0]    sel;
    logic             fire;
    logic             disp_acc;
    logic [CW-1:0]    wr_idx;
    logic [IW-1:0]    src_idx [DEPTH];
    logic [DEPTH-1:0] wr_en;
    entry_t           disp_raw, disp_e;

    // Capture a CDB broadcast into any operand that is still waiting on that tag.
    function automatic entry_t wake(entry_t e, logic v, logic [TAG_W-1:0] t,
                                    logic [DATA_W-1:0] d);
        entry_t r;
        r = e;
        if (v && !r.rs1_v && (r.rs1_tag == t)) begin
            r.rs1_v    = 1'b1;
            r.rs1_data = d;
        end
        if (v && !r.rs2_v && (r.rs2_tag == t)) begin
            r.rs2_v    = 1'b1;
            r.rs2_data = d;
        end
        return r;
    endfunction

    // Mark the ready entries (registered state only) and pick the oldest one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        sel = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            ready[i] = (i < int'(count_q)) && ent_q[i].rs1_v && ent_q[i].rs2_v;
            if (ready[i]) sel = IW'(i);
        end
    end

    assign issue_valid = |ready;
    assign fire        = issue_valid & issue_ready;
    assign queue_full  = (count_q == CW'(DEPTH));
    assign queue_count = count_q;
    assign disp_acc    = disp_valid & ~queue_full;
    // The new entry goes after the survivors, so it moves down one slot when an issue fires.
    assign wr_idx      = count_q - CW'(fire);

    // Per slot: which old slot feeds it (collapse), and whether dispatch writes it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i] = disp_acc && (wr_idx == CW'(i));
            if (fire && (IW'(i) >= sel) && (i < DEPTH-1)) src_idx[i] = IW'(i + 1);
            else                                           src_idx[i] = IW'(i);
        end
    end

    // Build the incoming entry. The bypass only fills operands that dispatch marked invalid.
    always_comb begin
        disp_raw.rs1_tag  = disp_rs1_tag;
        disp_raw.rs2_tag  = disp_rs2_tag;
        disp_raw.rs1_data = disp_rs1_data;
        disp_raw.rs2_data = disp_rs2_data;
        disp_raw.rs1_v    = disp_rs1_valid;
        disp_raw.rs2_v    = disp_rs2_valid;
        disp_raw.rd_tag   = disp_rd_tag;
        disp_raw.opcode   = disp_opcode;
        disp_raw.funct7   = disp_funct7;
        disp_raw.funct3   = disp_funct3;
        disp_e            = wake(disp_raw, cdb_valid, cdb_tag, cdb_data);
    end

    // Next entry contents: shifted or held, woken by the CDB, then overwritten by dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = wake(ent_q[src_idx[i]], cdb_valid, cdb_tag, cdb_data);
            if (wr_en[i]) ent_d[i] = disp_e;
        end
    end

    // Occupancy bookkeeping. Flush takes priority over dispatch and issue.
    always_comb begin
        count_d = count_q;
        if (flush) count_d = '0;
        else       count_d = count_q + CW'(disp_acc) - CW'(fire);
    end

    // Occupancy register. Validity of each slot follows from the count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // Entry payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately left unreset; the count alone decides which slots are live.
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end

    assign issue_rs1_data = ent_q[sel].rs1_data;
    assign issue_rs2_data = ent_q[sel].rs2_data;
    assign issue_rd_tag   = ent_q[sel].rd_tag;
    assign issue_opcode   = ent_q[sel].opcode;
    assign issue_funct7   = ent_q[sel].funct7;
    assign issue_funct3   = ent_q[sel].funct3;

    generate
        if (IMM_EN) begin : g_imm
            logic [DATA_W-1:0] imm_q [DEPTH];
            logic [DATA_W-1:0] imm_d [DEPTH];
            // Immediate slots follow the same shift and write pattern as the entries.
            always_comb begin
                for (int i = 0; i < DEPTH; i++)
                    imm_d[i] = wr_en[i] ? disp_imm : imm_q[src_idx[i]];
            end
            // Immediate storage register.
            always_ff @(posedge clk) begin
                for (int i = 0; i < DEPTH; i++) imm_q[i] <= imm_d[i];
            end
            assign issue_imm = imm_q[sel];
        end else begin : g_no_imm
            assign issue_imm = '0;
        end

        if (PC_EN) begin : g_pc
            logic [DATA_W-1:0] pc_q [DEPTH];
            logic [DATA_W-1:0] pc_d [DEPTH];
            // PC slots follow the same shift and write pattern as the entries.
            always_comb begin
                for (int i = 0; i < DEPTH; i++)
                    pc_d[i] = wr_en[i] ? disp_pc : pc_q[src_idx[i]];
            end
            // PC storage register.
            always_ff @(posedge clk) begin
                for (int i = 0; i < DEPTH; i++) pc_q[i] <= pc_d[i];
            end
            assign issue_pc = pc_q[sel];
        end else begin : g_no_pc
            assign issue_pc = '0;
        end
    endgenerate

endmodule

// File: tb/tb_issue_queue_gen.sv
// Directed bench for issue_queue_gen. An age-ordered queue model predicts the
// outputs and is compared with the DUT every cycle. Literal checks pin the
// model to hand-computed values.
module tb_issue_queue_gen;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk, rst, flush;
    logic              disp_valid;
    logic [TAG_W-1:0]  disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
    logic [DATA_W-1:0] disp_rs1_data, disp_rs2_data, disp_imm, disp_pc;
    logic              disp_rs1_valid, disp_rs2_valid;
    logic [6:0]        disp_opcode, disp_funct7;
    logic [2:0]        disp_funct3;
    logic              queue_full;
    logic [CW-1:0]     queue_count;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_valid, issue_ready;
    logic [DATA_W-1:0] issue_rs1_data, issue_rs2_data, issue_imm, issue_pc;
    logic [TAG_W-1:0]  issue_rd_tag;
    logic [6:0]        issue_opcode, issue_funct7;
    logic [2:0]        issue_funct3;

    int n_vec  = 0;
    int n_miss = 0;
    bit started = 0;

    issue_queue_gen #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .IMM_EN(1'b1), .PC_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_rs1_valid(disp_rs1_valid), .disp_rs2_valid(disp_rs2_valid),
        .disp_rd_tag(disp_rd_tag), .disp_opcode(disp_opcode),
        .disp_funct7(disp_funct7), .disp_funct3(disp_funct3),
        .disp_imm(disp_imm), .disp_pc(disp_pc),
        .queue_full(queue_full), .queue_count(queue_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_rd_tag(issue_rd_tag), .issue_opcode(issue_opcode),
        .issue_funct7(issue_funct7), .issue_funct3(issue_funct3),
        .issue_imm(issue_imm), .issue_pc(issue_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: an age-ordered queue of micro-ops.
    typedef struct {
        logic [TAG_W-1:0]  r1t, r2t, rd;
        logic [DATA_W-1:0] r1d, r2d, imm, pc;
        bit                r1v, r2v;
        logic [6:0]        opc, f7;
        logic [2:0]        f3;
    } m_t;
    m_t mq[$];

    // Mid-cycle: compare the DUT with the model, then advance the model by the coming edge.
    always @(negedge clk) begin
        int  idx;
        bit  ev, fire, acc;
        m_t  ne;
        idx = -1;
        foreach (mq[k]) if (idx < 0 && mq[k].r1v && mq[k].r2v) idx = k;
        ev = (idx >= 0);
        if (started) begin
            check("count", queue_count, mq.size());
            check("full", queue_full, mq.size() == DEPTH);
            check("issue_valid", issue_valid, ev);
            if (ev) begin
                check("rd_tag", issue_rd_tag, mq[idx].rd);
                check("rs1_data", issue_rs1_data, mq[idx].r1d);
                check("rs2_data", issue_rs2_data, mq[idx].r2d);
                check("opcode", issue_opcode, mq[idx].opc);
                check("funct7", issue_funct7, mq[idx].f7);
                check("funct3", issue_funct3, mq[idx].f3);
                check("imm", issue_imm, mq[idx].imm);
                check("pc", issue_pc, mq[idx].pc);
            end
        end
        if (rst || flush) begin
            mq.delete();
        end else begin
            fire = ev && issue_ready;
            acc  = disp_valid && (mq.size() < DEPTH);
            if (disp_valid && !acc)
                $display("protocol error: dispatch while full at %0t, dropped", $time);
            ne.r1t = disp_rs1_tag;  ne.r2t = disp_rs2_tag;  ne.rd = disp_rd_tag;
            ne.r1d = disp_rs1_data; ne.r2d = disp_rs2_data;
            ne.r1v = disp_rs1_valid; ne.r2v = disp_rs2_valid;
            ne.opc = disp_opcode; ne.f7 = disp_funct7; ne.f3 = disp_funct3;
            ne.imm = disp_imm; ne.pc = disp_pc;
            if (cdb_valid && !ne.r1v && ne.r1t == cdb_tag) begin ne.r1v = 1; ne.r1d = cdb_data; end
            if (cdb_valid && !ne.r2v && ne.r2t == cdb_tag) begin ne.r2v = 1; ne.r2d = cdb_data; end
            foreach (mq[k]) begin
                if (cdb_valid && !mq[k].r1v && mq[k].r1t == cdb_tag) begin mq[k].r1v = 1; mq[k].r1d = cdb_data; end
                if (cdb_valid && !mq[k].r2v && mq[k].r2t == cdb_tag) begin mq[k].r2v = 1; mq[k].r2d = cdb_data; end
            end
            if (fire) mq.delete(idx);
            if (acc)  mq.push_back(ne);
        end
    end

    task automatic idle();
        disp_valid = 0; cdb_valid = 0; flush = 0;
        disp_rs1_tag = '0; disp_rs2_tag = '0; disp_rd_tag = '0;
        disp_rs1_data = '0; disp_rs2_data = '0; disp_rs1_valid = 0; disp_rs2_valid = 0;
        disp_opcode = '0; disp_funct7 = '0; disp_funct3 = '0; disp_imm = '0; disp_pc = '0;
        cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [TAG_W-1:0] rd,
                        input logic [TAG_W-1:0] t1, input logic v1, input logic [DATA_W-1:0] d1,
                        input logic [TAG_W-1:0] t2, input logic v2, input logic [DATA_W-1:0] d2);
        disp_valid = 1; disp_rd_tag = rd;
        disp_rs1_tag = t1; disp_rs1_valid = v1; disp_rs1_data = d1;
        disp_rs2_tag = t2; disp_rs2_valid = v2; disp_rs2_data = d2;
        disp_opcode = 7'(rd) + 7'h10; disp_funct7 = 7'(rd) ^ 7'h55; disp_funct3 = rd[2:0];
        disp_imm = 32'h1000 + 32'(rd); disp_pc = 32'h8000_0000 + {24'h0, rd, 2'b00};
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    initial begin
        idle(); issue_ready = 0; rst = 1;
        tick(); tick(); rst = 0;
        #1;
        check("rst count", queue_count, 0);
        check("rst full", queue_full, 0);
        check("rst issue_valid", issue_valid, 0);
        started = 1;

        // 1: four ready entries issue in age order, full only at four
        for (int k = 1; k <= 4; k++) begin
            disp(6'(k), 0, 1, 32'h100 + k, 0, 1, 32'h200 + k);
            tick();
        end
        idle(); #1;
        check("t1 count", queue_count, 4);
        issue_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            check("t1 order", issue_rd_tag, k);
            check("t1 full", queue_full, k == 1);
            tick(); #1;
        end
        check("t1 drained", queue_count, 0);
        check("t1 idle", issue_valid, 0);

        // 2: younger ready entry overtakes; CDB wakeup releases the older one
        disp(5, 9, 0, 0, 2, 1, 32'h55); tick();
        disp(6, 1, 1, 32'h61, 2, 1, 32'h62); tick();
        idle(); #1;
        check("t2 B first", issue_rd_tag, 6);
        tick(); #1;
        check("t2 A waits", issue_valid, 0);
        cdb(9, 32'hDEAD_BEEF); tick(); idle(); #1;
        check("t2 A woken", issue_rd_tag, 5);
        check("t2 A rs1", issue_rs1_data, 32'hDEAD_BEEF);
        tick(); #1;
        check("t2 empty", queue_count, 0);

        // 3: same-cycle dispatch bypass; a valid operand keeps its dispatch data
        disp(7, 5, 1, 32'hAAAA, 5, 0, 0); cdb(5, 32'h1234); tick(); idle(); #1;
        check("t3 rd", issue_rd_tag, 7);
        check("t3 rs2 bypass", issue_rs2_data, 32'h1234);
        check("t3 rs1 kept", issue_rs1_data, 32'hAAAA);
        tick(); #1;

        // 4: dispatch into a full queue is dropped, no same-cycle issue credit
        issue_ready = 0;
        for (int k = 10; k <= 13; k++) begin
            disp(6'(k), 0, 1, k, 0, 1, k);
            tick();
        end
        disp(14, 0, 1, 14, 0, 1, 14); tick(); #1;
        check("t4 count", queue_count, 4);
        check("t4 no overwrite", issue_rd_tag, 10);
        disp(15, 0, 1, 15, 0, 1, 15); issue_ready = 1; tick(); idle(); #1;
        check("t4 count after", queue_count, 3);
        check("t4 next", issue_rd_tag, 11);
        tick(); tick(); tick(); #1;
        check("t4 drained", queue_count, 0);

        // 5: middle entry issues while a new one dispatches; age order survives
        issue_ready = 0;
        disp(20, 3, 0, 0, 1, 1, 32'h201); tick();
        disp(21, 1, 1, 32'h211, 1, 1, 32'h212); tick();
        disp(22, 1, 1, 32'h221, 4, 0, 0); tick();
        disp(23, 1, 1, 32'h231, 1, 1, 32'h232); issue_ready = 1; #1;
        check("t5 middle sel", issue_rd_tag, 21);
        tick(); idle(); issue_ready = 0; #1;
        check("t5 count", queue_count, 3);
        check("t5 newest", issue_rd_tag, 23);
        cdb(4, 32'h4444); tick(); idle(); #1;
        check("t5 older wins", issue_rd_tag, 22);
        check("t5 rs2", issue_rs2_data, 32'h4444);
        cdb(3, 32'h3333); tick(); idle(); #1;
        check("t5 oldest", issue_rd_tag, 20);
        check("t5 rs1", issue_rs1_data, 32'h3333);

        // 6: flush beats dispatch and wakeup; next dispatch lands at slot 0
        flush = 1; disp(30, 0, 1, 1, 0, 1, 1); cdb(3, 32'h9); tick(); idle(); #1;
        check("t6 count", queue_count, 0);
        check("t6 idle", issue_valid, 0);
        disp(31, 0, 1, 32'h311, 0, 1, 32'h312); tick(); idle(); #1;
        check("t6 slot0", issue_rd_tag, 31);
        check("t6 imm", issue_imm, 32'h1000 + 31);
        issue_ready = 1; tick(); #1;
        check("t6 drained", queue_count, 0);

        // reset in the middle of operation behaves like flush
        issue_ready = 0;
        disp(40, 0, 1, 1, 0, 1, 1); tick();
        disp(41, 0, 1, 2, 0, 1, 2); tick(); idle();
        rst = 1; tick(); rst = 0; #1;
        check("mid rst count", queue_count, 0);
        check("mid rst idle", issue_valid, 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/issue_queue_gen.md
Name: issue_queue_gen

Overview:
Parametrised, collapsing, in-order-priority issue queue (reservation station) for one execution unit.
- Accepts dispatched micro-ops with operand tag/data/valid.
- Captures missing operands from the CDB (wakeup), including same-cycle dispatch bypass.
- Issues the oldest entry with both operands ready over a valid/ready handshake.
- Sits between dispatch and an integer/branch/memory execution unit; generalises the fixed 4-entry queue to DEPTH entries, with flush and occupancy reporting.

Parameters:
DEPTH, 4, number of entries (2..32)
TAG_W, 6, physical tag width
DATA_W, 32, operand/immediate/PC width
IMM_EN, 1, store immediate field (0: imm storage removed, issue_imm driven 0)
PC_EN, 1, store PC field (0: pc storage removed, issue_pc driven 0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all entries
disp_valid  in  1  dispatch request
disp_rs1_tag, disp_rs2_tag  in  TAG_W  source tags
disp_rs1_data, disp_rs2_data  in  DATA_W  source data
disp_rs1_valid, disp_rs2_valid  in  1  source data already valid
disp_rd_tag  in  TAG_W  destination tag
disp_opcode, disp_funct7  in  7  decode fields
disp_funct3  in  3  decode field
disp_imm, disp_pc  in  DATA_W  immediate, PC
queue_full  out  1  count==DEPTH
queue_count  out  $clog2(DEPTH+1)  occupied entries
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB tag
cdb_data  in  DATA_W  CDB data
issue_valid  out  1  issue slot holds a ready entry
issue_ready  in  1  execution unit accepts
issue_rs1_data, issue_rs2_data  out  DATA_W  operands
issue_rd_tag  out  TAG_W  destination
issue_opcode, issue_funct7  out  7  decode fields
issue_funct3  out  3  decode field
issue_imm, issue_pc  out  DATA_W  immediate, PC

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset: all entry valid bits 0, queue_count=0, queue_full=0, issue_valid=0; data fields need no reset.
- Storage: entries 0..count-1 valid, index 0 oldest, no holes.
- Dispatch:
  - Accepted when disp_valid & !queue_full. queue_full depends only on registered count; no same-cycle issue credit.
  - Written at index count-removed, where removed=1 if an issue handshake fires that cycle.
  - Dispatch while full is ignored and the entry is dropped; the bench flags it as a protocol error.
- Wakeup:
  - Each cycle cdb_valid=1 sets rsN_valid=1 and rsN_data=cdb_data in every stored entry whose rsN_valid=0 and rsN_tag==cdb_tag.
  - The same rule applies to the entry being dispatched (bypass); disp_rsN_valid=1 takes precedence.
- Ready: entry ready = valid & rs1_valid & rs2_valid, evaluated on registered state only.
  - An entry woken or dispatched in cycle N is eligible from cycle N+1; minimum dispatch-to-issue latency is 1 cycle.
- Select: the lowest-index ready entry drives all issue_* outputs combinationally; issue_valid = any ready.
  - With no ready entry, issue_* data is don't-care.
- Handshake:
  - Issue fires when issue_valid & issue_ready; the selected entry is removed at the clock edge.
  - Entries above it shift down one index; wakeup updates apply to shifted entries in the same edge.
  - Outputs must stay stable while issue_valid=1 & issue_ready=0, unless an older entry becomes ready, which changes the selection.
- Count: count_next = count + accepted_dispatch - fired_issue. Dispatch and issue in the same cycle leave count unchanged.
- Flush: has priority over dispatch, wakeup and issue in that cycle. Next cycle count=0, issue_valid=0. The handshake firing in the flush cycle is still consumed by the EU; the team accepts this.
- Reset mid-operation: identical to flush; data fields are left stale.
- IMM_EN/PC_EN=0: the corresponding registers are not instantiated and the outputs are tied to 0.

Test Plan:
1. Reset, then dispatch 4 entries with both operands valid (rd 1..4), issue_ready=1 -> issue rd order 1,2,3,4 on consecutive cycles; count 4→0; queue_full high only while count=4.
2. Dispatch A (rs1_tag=9, invalid), then B (ready); issue_ready=1 -> B issues first. Then cdb_valid, tag=9, data=0xDEADBEEF -> A issues next cycle with rs1_data=0xDEADBEEF.
3. Dispatch an entry with rs2_tag=5 invalid in the same cycle as CDB tag=5, data=0x1234 -> entry issues the next cycle with rs2_data=0x1234.
4. Fill to DEPTH with issue_ready=0, then assert disp_valid -> queue_full=1, count stays DEPTH, no overwrite. Then issue_ready=1 plus dispatch in the same cycle -> count stays DEPTH-1 afterwards? No: the dispatch is rejected (full), so count goes DEPTH→DEPTH-1.
5. count=3, the middle entry issues while a new dispatch arrives -> the remaining entries compact and the new entry lands at index 2; count=3; age order preserved.
6. count=3, assert flush together with disp_valid and cdb_valid -> next cycle count=0, issue_valid=0; a subsequent dispatch lands at index 0.
